// File: rtl/fifo_rd_packer.sv
`timescale 1ns/1ps
// fifo_rd_packer: drains a 1-cycle-latency FIFO read port and packs BEATS bytes per valid/ready word.
// Define FIFO_PACK_FLUSH_EN to add flush_i / m_keep_o for emitting partially filled words.
module fifo_rd_packer #(
    parameter int WIDTH     = 8,
    parameter int BEATS     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fifo_empty_i,
    input  logic [WIDTH-1:0]       fifo_rdata_i,
    output logic                   fifo_rd_en_o,
    output logic [WIDTH*BEATS-1:0] m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
`ifdef FIFO_PACK_FLUSH_EN
    ,
    input  logic                   flush_i,
    output logic [BEATS-1:0]       m_keep_o
`endif
);

    localparam logic [CNT_WIDTH:0]   BEATS_C   = (CNT_WIDTH+1)'(BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(BEATS-1);

    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic                          pend_q;
    logic [BEATS-1:0][WIDTH-1:0]   lanes_q, lanes_d;
    logic [WIDTH*BEATS-1:0]        m_data_q, m_data_d;
    logic                          m_valid_q, m_valid_d;
    logic                          flush_req;
    logic [CNT_WIDTH:0]            inflight;

`ifdef FIFO_PACK_FLUSH_EN
    logic                          flush_req_q, flush_req_d;
    logic [BEATS-1:0]              keep_q, keep_d;

    // A fresh pulse blocks reads in its own cycle, before flush_req_q catches it.
    assign flush_req = flush_req_q | flush_i;
    assign m_keep_o  = keep_q;
`else
    assign flush_req = 1'b0;
`endif

    // Lanes already captured plus the read still in flight must not exceed one word.
    assign inflight     = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, pend_q};
    assign fifo_rd_en_o = !fifo_empty_i && !m_valid_q && !flush_req && (inflight < BEATS_C);
    assign m_data_o     = m_data_q;
    assign m_valid_o    = m_valid_q;

    always_comb begin
        cnt_d     = cnt_q;
        lanes_d   = lanes_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
`ifdef FIFO_PACK_FLUSH_EN
        keep_d      = keep_q;
        flush_req_d = flush_req_q | flush_i;
`endif

        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end

        if (pend_q) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_q == CNT_WIDTH'(k)) begin
                    lanes_d[k] = fifo_rdata_i;
                end
            end
            if (cnt_q == LAST_LANE) begin
                m_data_d  = lanes_d;
                m_valid_d = 1'b1;
                cnt_d     = '0;
                lanes_d   = '0;
`ifdef FIFO_PACK_FLUSH_EN
                keep_d    = '1;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

`ifdef FIFO_PACK_FLUSH_EN
        // Resolve only once no byte is in flight and the output slot is free.
        if (flush_req_q && !pend_q && !m_valid_q) begin
            flush_req_d = flush_i;
            if (cnt_q != '0) begin
                m_data_d  = lanes_q;
                m_valid_d = 1'b1;
                cnt_d     = '0;
                lanes_d   = '0;
                for (int k = 0; k < BEATS; k++) begin
                    keep_d[k] = (CNT_WIDTH'(k) < cnt_q);
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            lanes_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
            keep_q      <= '0;
            flush_req_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= fifo_rd_en_o;
            lanes_q   <= lanes_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
`ifdef FIFO_PACK_FLUSH_EN
            keep_q      <= keep_d;
            flush_req_q <= flush_req_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
`timescale 1ns/1ps
// Bench for fifo_rd_packer: a 16x8 registered-read FIFO model feeds the DUT; a byte-stream
// scoreboard checks every presented word, plus directed literal expectations.
module tb_fifo_rd_packer;
    localparam int WIDTH     = 8;
    localparam int BEATS     = 4;
    localparam int CNT_WIDTH = 3;
    localparam int W         = WIDTH * BEATS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty;
    logic [WIDTH-1:0] rdata = '0;
    logic             rd_en;
    logic [W-1:0]     m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
    logic             flush = 1'b0;
    logic [BEATS-1:0] keep;
`endif

    always #5 clk = ~clk;

    fifo_rd_packer #(.WIDTH(WIDTH), .BEATS(BEATS), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_rdata_i (rdata),
        .fifo_rd_en_o (rd_en),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready)
`ifdef FIFO_PACK_FLUSH_EN
        ,
        .flush_i      (flush),
        .m_keep_o     (keep)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: 16 entries, read data registered one cycle after a read request.
    logic [7:0] f_mem [16];
    int         f_wp = 0, f_rp = 0, f_count = 0;
    logic       f_hold = 1'b1;
    logic       f_rd_err = 1'b0;
    logic       push_req = 1'b0;
    logic [7:0] push_data = '0;
    logic [7:0] exp_q [$];

    assign fifo_empty = (f_count == 0) || f_hold;

    always @(posedge clk) begin : fifo_model
        int c;
        c = f_count;
        if (rd_en) begin
            if (fifo_empty) begin
                f_rd_err <= 1'b1;
            end else begin
                rdata <= f_mem[f_rp];
                exp_q.push_back(f_mem[f_rp]);
                f_rp  <= (f_rp + 1) % 16;
                c     = c - 1;
            end
        end else begin
            rdata <= 8'($urandom);
        end
        if (push_req) begin
            f_mem[f_wp] <= push_data;
            f_wp        <= (f_wp + 1) % 16;
            c           = c + 1;
        end
        if (rst) exp_q.delete();
        f_count <= c;
    end

    // Scoreboard: a presented word must be the next delivered bytes, lane 0 first, zero-padded.
    logic [W-1:0]     acc_w [$];
    logic [BEATS-1:0] acc_k [$];
    logic             prev_hold = 1'b0;
    logic [W-1:0]     prev_data = '0;

    always @(negedge clk) begin : compare
        int n;
        logic [W-1:0]     ew;
        logic [BEATS-1:0] ek;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (rd_en) check("rd_gating", {fifo_empty, m_valid}, 2'b00);
            if (prev_hold) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                n  = (exp_q.size() < BEATS) ? exp_q.size() : BEATS;
                ew = '0;
                ek = '0;
                for (int k = 0; k < n; k++) begin
                    ew[k*WIDTH +: WIDTH] = exp_q[k];
                    ek[k] = 1'b1;
                end
                check("inflight_le_beats", exp_q.size() <= BEATS, 1'b1);
`ifdef FIFO_PACK_FLUSH_EN
                check("word_nonempty", n > 0, 1'b1);
                check("word_keep", keep, ek);
`else
                check("word_len", n, BEATS);
`endif
                check("word_data", m_data, ew);
                if (m_ready) begin
                    for (int k = 0; k < n; k++) void'(exp_q.pop_front());
                    acc_w.push_back(m_data);
                    acc_k.push_back(ek);
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        push_req  = 1'b1;
        push_data = b;
        tick(1);
        push_req  = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int i;
        i = 0;
        while (acc_w.size() < n && i < budget) begin
            tick(1);
            i++;
        end
        check("wait_words", acc_w.size() >= n, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (!m_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("wait_valid", m_valid, 1'b1);
    endtask

    int pushed;
    int cyc;
    int base;

    initial begin
        // Reset with the FIFO held empty.
        rst = 1'b1; f_hold = 1'b1; m_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", m_valid, 1'b0);
        check("reset_data", m_data, 32'h0);
        check("reset_rd_en", rd_en, 1'b0);
`ifdef FIFO_PACK_FLUSH_EN
        check("reset_keep", keep, 4'h0);
`endif
        @(posedge clk); #2;

        // Test 1: four preloaded bytes, reads back-to-back, word one cycle after the last read lands.
        m_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        f_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_rd_en_burst", rd_en, 1'b1);
        end
        @(negedge clk);
        check("t1_rd_en_stop", rd_en, 1'b0);
        check("t1_not_yet_valid", m_valid, 1'b0);
        @(negedge clk);
        check("t1_valid", m_valid, 1'b1);
        check("t1_data", m_data, 32'h04030201);
        @(posedge clk); #2;
        wait_words(1, 20);
        if (acc_w.size() >= 1) check("t1_acc", acc_w[0], 32'h04030201);

        // Test 2: back-pressure holds the first word and blocks reads.
        m_ready = 1'b0;
        f_hold  = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        f_hold = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_valid_held", m_valid, 1'b1);
            check("t2_data_held", m_data, 32'h13121110);
            check("t2_no_read", rd_en, 1'b0);
        end
        @(posedge clk); #2;
        m_ready = 1'b1;
        wait_words(3, 30);
        if (acc_w.size() >= 3) begin
            check("t2_word1", acc_w[1], 32'h13121110);
            check("t2_word2", acc_w[2], 32'h17161514);
        end

        // Test 3: FIFO runs dry mid-word, packing resumes when bytes arrive.
        push(8'hAA); push(8'hBB);
        tick(3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_idle_rd_en", rd_en, 1'b0);
            check("t3_no_partial", m_valid, 1'b0);
        end
        @(posedge clk); #2;
        push(8'hCC); push(8'hDD);
        wait_words(4, 20);
        if (acc_w.size() >= 4) check("t3_word", acc_w[3], 32'hDDCCBBAA);

        // Test 4: reset while the second read of a word is in flight.
        f_hold = 1'b1;
        push(8'h30); push(8'h31);
        f_hold = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid_cleared", m_valid, 1'b0);
        check("t4_data_cleared", m_data, 32'h0);
        @(posedge clk); #2;
        push(8'h40); push(8'h41); push(8'h42); push(8'h43);
        wait_words(5, 20);
        if (acc_w.size() >= 5) check("t4_clean_word", acc_w[4], 32'h43424140);

`ifdef FIFO_PACK_FLUSH_EN
        // Test 5: flush a three-lane partial word, then a flush with nothing to emit.
        push(8'h21); push(8'h22); push(8'h23);
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_words(6, 20);
        if (acc_w.size() >= 6) begin
            check("t5_flush_data", acc_w[5], 32'h00232221);
            check("t5_flush_keep", acc_k[5], 4'b0111);
        end
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_empty_flush", m_valid, 1'b0);
        end
        @(posedge clk); #2;
        check("t5_word_count", acc_w.size(), 6);
`endif

        // Test 6: random push / ready pattern, 200 bytes, stream order checked by the scoreboard.
        base   = acc_w.size();
        pushed = 0;
        cyc    = 0;
        while (pushed < 200 && cyc < 5000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && f_count < 16) begin
                push(8'(pushed * 7 + 3));
                pushed++;
            end else begin
                tick(1);
            end
            cyc++;
        end
        check("t6_all_pushed", pushed, 200);
        m_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || f_count != 0 || m_valid) && cyc < 400) begin
            tick(1);
            cyc++;
        end
        tick(8);
        check("t6_word_count", acc_w.size() - base, 50);
        check("t6_stream_drained", exp_q.size(), 0);
        check("t6_fifo_drained", f_count, 0);
        check("fifo_read_error", f_rd_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
